// File: rtl/div_restoring.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// followed by a single sign-fix cycle. Quotient goes to lo_out, remainder to
// hi_out. A zero divisor is flagged instead of being run through the loop.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; a zero divisor is answered from here
//   RUN   | WIDTH shift/compare/subtract iterations on the magnitudes
//   FIX   | apply result signs, publish hi/lo, pulse done
module div_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] mag_b;
  logic             sign_a;
  logic             sign_q;

  logic             b_zero;
  logic             last_iter;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             fits;

  assign b_zero    = (b_in == '0);
  assign last_iter = (count == CW'(WIDTH - 1));
  assign busy      = (state != IDLE);

  // The partial remainder is always below |b|, so one extra bit is enough
  // to hold the shifted value and make the compare safe at any magnitude.
  assign rem_sh   = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, mag_b};
  assign fits     = (rem_sh >= {1'b0, mag_b});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !b_zero) state_next = RUN;
      RUN:  if (last_iter)        state_next = FIX;
      FIX:                        state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix and result publication
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_q   <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b_zero) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              // Negating the most negative value wraps to itself, which is
              // exactly its magnitude when read as unsigned.
              quo      <= a_in[WIDTH-1] ? -a_in : a_in;
              mag_b    <= b_in[WIDTH-1] ? -b_in : b_in;
              sign_a   <= a_in[WIDTH-1];
              sign_q   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              rem      <= '0;
              count    <= '0;
              div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          rem   <= fits ? rem_diff : rem_sh;
          quo   <= {quo[WIDTH-2:0], fits};
          count <= count + 1'b1;
        end
        FIX: begin
          lo_out <= sign_q ? -quo : quo;
          hi_out <= sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Randomised and directed bench for div_restoring against a 64-bit
// arithmetic reference of signed division (truncating, remainder follows
// the dividend).
module tb_div_restoring;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_zero;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  div_restoring #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .div_zero (div_zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: widen to 64 bits so the most-negative / -1 case cannot
  // overflow, then keep the low 32 bits (which gives the silent wrap).
  task automatic model(input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) begin
      exp_dz = 1'b1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
      exp_dz = 1'b0;
    end
  endtask

  // One division. poke_at > 0 asserts a stray start (a=1,b=1) so it is
  // sampled on that edge after the start edge while the unit is busy.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int poke_at);
    int          n;
    logic        seen_busy;
    logic        stable;
    logic [31:0] hi0, lo0;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    hi0   = hi_out;
    lo0   = lo_out;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    n         = 0;
    seen_busy = 1'b0;
    stable    = 1'b1;
    while (!done && n < 40) begin
      if (busy) seen_busy = 1'b1;
      if (hi_out !== hi0 || lo_out !== lo0) stable = 1'b0;
      if (poke_at > 0 && n == poke_at - 1) begin
        start = 1'b1;
        a_in  = 32'd1;
        b_in  = 32'd1;
      end
      @(posedge clk);
      #1;
      n++;
      if (poke_at > 0 && n == poke_at) start = 1'b0;
    end
    start = 1'b0;
    model(a, b);
    check("latency", 32'(n), (b == 32'd0) ? 32'd0 : 32'd33);
    check("lo", lo_out, exp_lo);
    check("hi", hi_out, exp_hi);
    check("div_zero", {31'd0, div_zero}, {31'd0, exp_dz});
    check("busy_seen", {31'd0, seen_busy}, {31'd0, (b != 32'd0)});
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("hilo_stable", {31'd0, stable}, 32'd1);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic        seen_done;
    logic [31:0] ra, rb;
    int          sel, poke;

    reset = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_flags", {29'd0, div_zero, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op(32'd7, 32'd2, 0);
    do_op(32'd5, 32'd0, 0);
    do_op(32'hFFFF_FFF9, 32'd2, 0);
    do_op(32'd7, 32'hFFFF_FFFE, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(32'h8000_0000, 32'd1, 0);
    do_op(32'd100, 32'd7, 5);

    // Reset in the middle of a division: outputs clear at once, no done.
    @(negedge clk);
    a_in  = 32'd100;
    b_in  = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    check("midrst_hi", hi_out, 32'd0);
    check("midrst_lo", lo_out, 32'd0);
    check("midrst_flags", {29'd0, div_zero, busy, done}, 32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_nodone", {31'd0, seen_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(32'd9, 32'd3, 0);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 30);
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      poke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 31) : 0;
      do_op(ra, rb, poke);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
